// File: rtl/fourier_harmonic_analyzer.sv
// Fourier harmonic analyzer: correlates a stream of 8-bit unsigned samples
// against square-wave sine/cosine references for the odd harmonics
// 1,3,5,... over one phase-accumulator frame. At the frame end it streams
// out one (I, Q) pair per harmonic through a valid/ready handshake.
module fourier_harmonic_analyzer #(
    parameter int PHASE_WIDTH   = 16,
    parameter int PHASE_STEP    = 256,
    parameter int MAX_HARMONICS = 4,
    localparam int FRAME_LOG2   = PHASE_WIDTH - $clog2(PHASE_STEP),
    localparam int ACC_W        = 9 + FRAME_LOG2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              sample_in,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [7:0]              res_harm,
    output logic signed [ACC_W-1:0] res_i,
    output logic signed [ACC_W-1:0] res_q,
    output logic                    res_last
);

    localparam int HW = (MAX_HARMONICS > 1) ? $clog2(MAX_HARMONICS) : 1;
    localparam logic [PHASE_WIDTH-1:0] STEP_INC   = PHASE_WIDTH'(PHASE_STEP);
    // Phase of the final sample of a frame: 2^PHASE_WIDTH - PHASE_STEP.
    localparam logic [PHASE_WIDTH-1:0] LAST_PHASE = ~PHASE_WIDTH'(PHASE_STEP - 1);
    localparam logic [HW-1:0]          LAST_H     = HW'(MAX_HARMONICS - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        DUMP  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [PHASE_WIDTH-1:0]  phase_q, phase_d;
    logic [HW-1:0]           h_q, h_d;
    logic signed [ACC_W-1:0] acc_i_q [MAX_HARMONICS];
    logic signed [ACC_W-1:0] acc_i_d [MAX_HARMONICS];
    logic signed [ACC_W-1:0] acc_q_q [MAX_HARMONICS];
    logic signed [ACC_W-1:0] acc_q_d [MAX_HARMONICS];
    logic [MAX_HARMONICS-1:0] sin_neg;
    logic [MAX_HARMONICS-1:0] cos_neg;
    logic signed [8:0]       x_s;
    logic signed [ACC_W-1:0] x_ext;

    // Re-centre the sample around zero and sign-extend to accumulator width.
    assign x_s   = {1'b0, sample_in} - 9'd128;
    assign x_ext = {{(ACC_W - 9){x_s[8]}}, x_s};

    // Reference signs per harmonic: only the top two bits of phase*n matter,
    // the multiply wraps naturally at PHASE_WIDTH bits.
    for (genvar gi = 0; gi < MAX_HARMONICS; gi++) begin : g_harm
        localparam logic [PHASE_WIDTH-1:0] HARM_N = PHASE_WIDTH'(2 * gi + 1);
        logic [1:0] ph_top;
        assign ph_top      = 2'((phase_q * HARM_N) >> (PHASE_WIDTH - 2));
        assign sin_neg[gi] = ph_top[1];
        assign cos_neg[gi] = ph_top[1] ^ ph_top[0];
    end

    // Next-state, accumulation and result presentation.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        h_d          = h_q;
        acc_i_d      = acc_i_q;
        acc_q_d      = acc_q_q;
        sample_ready = 1'b0;
        res_valid    = 1'b0;
        res_harm     = 8'd0;
        res_i        = '0;
        res_q        = '0;
        res_last     = 1'b0;
        case (state_q)
            ACCUM: begin
                sample_ready = 1'b1;
                if (sample_valid) begin
                    phase_d = phase_q + STEP_INC;
                    for (int n = 0; n < MAX_HARMONICS; n++) begin
                        acc_i_d[n] = sin_neg[n] ? acc_i_q[n] - x_ext : acc_i_q[n] + x_ext;
                        acc_q_d[n] = cos_neg[n] ? acc_q_q[n] - x_ext : acc_q_q[n] + x_ext;
                    end
                    if (phase_q == LAST_PHASE) begin
                        state_d = DUMP;
                    end
                end
            end
            DUMP: begin
                res_valid = 1'b1;
                res_harm  = {7'(h_q), 1'b1};
                res_i     = acc_i_q[h_q];
                res_q     = acc_q_q[h_q];
                res_last  = (h_q == LAST_H);
                if (res_ready) begin
                    if (h_q == LAST_H) begin
                        // Phase has already wrapped to 0; start a clean frame.
                        state_d = ACCUM;
                        h_d     = '0;
                        for (int n = 0; n < MAX_HARMONICS; n++) begin
                            acc_i_d[n] = '0;
                            acc_q_d[n] = '0;
                        end
                    end else begin
                        h_d = h_q + HW'(1);
                    end
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            phase_q <= '0;
            h_q     <= '0;
            for (int n = 0; n < MAX_HARMONICS; n++) begin
                acc_i_q[n] <= '0;
                acc_q_q[n] <= '0;
            end
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            h_q     <= h_d;
            acc_i_q <= acc_i_d;
            acc_q_q <= acc_q_d;
        end
    end

endmodule
